// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Inter-stage pipeline register (IR/PC/EXC/BD/valid) with
//                stall, flush and bubble modes and a saturating stall counter.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int          IR_W           = 32,
    parameter int          PC_W           = 32,
    parameter int          EXC_W          = 5,
    parameter logic [31:0] RESET_PC       = 32'h0000_3000,
    parameter int          CNT_W          = 16,
    parameter bit          BUBBLE_KEEP_PC = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             bubble,
    input  logic [PC_W-1:0]  flush_pc,
    input  logic [IR_W-1:0]  ir_in,
    input  logic [PC_W-1:0]  pc_in,
    input  logic [EXC_W-1:0] exc_in,
    input  logic             bd_in,
    input  logic             valid_in,
    output logic [IR_W-1:0]  ir_out,
    output logic [PC_W-1:0]  pc_out,
    output logic [EXC_W-1:0] exc_out,
    output logic             bd_out,
    output logic             valid_out,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [PC_W-1:0]  C_RESET_PC = PC_W'(RESET_PC);
    localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;

    logic [IR_W-1:0]  ir_q,    ir_d;
    logic [PC_W-1:0]  pc_q,    pc_d;
    logic [EXC_W-1:0] exc_q,   exc_d;
    logic             bd_q,    bd_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // A plain if-chain: an unknown control falls through to the next mode,
    // so X/Z on flush/stall/bubble behaves as deasserted.
    always_comb begin
        ir_d    = ir_q;
        pc_d    = pc_q;
        exc_d   = exc_q;
        bd_d    = bd_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (flush) begin
            ir_d    = '0;
            pc_d    = flush_pc;
            exc_d   = '0;
            bd_d    = 1'b0;
            valid_d = 1'b0;
        end else if (stall) begin
            if (cnt_q != C_CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (bubble) begin
            ir_d    = '0;
            pc_d    = BUBBLE_KEEP_PC ? pc_in : '0;
            exc_d   = '0;
            bd_d    = 1'b0;
            valid_d = 1'b0;
        end else begin
            ir_d    = ir_in;
            pc_d    = pc_in;
            exc_d   = valid_in ? exc_in : '0;
            bd_d    = bd_in;
            valid_d = valid_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q    <= '0;
            pc_q    <= C_RESET_PC;
            exc_q   <= '0;
            bd_q    <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            exc_q   <= exc_d;
            bd_q    <= bd_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ir_out    = ir_q;
    assign pc_out    = pc_q;
    assign exc_out   = exc_q;
    assign bd_out    = bd_q;
    assign valid_out = valid_q;
    assign stall_cnt = cnt_q;

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register for the five-stage MIPS datapath. It replaces the fixed-width per-stage registers and carries the following between any two adjacent stages: instruction word, PC, exception code, branch-delay flag and a valid bit. It adds flush and bubble-insertion modes on top of stall/hold, so precise exceptions can recover the EPC. It also keeps a saturating stall-cycle counter for performance debug.

Parameters:
IR_W, 32, instruction word width
PC_W, 32, PC field width
EXC_W, 5, exception code width (0 = no exception)
RESET_PC, 32'h00003000, PC loaded on reset (truncated to PC_W)
CNT_W, 16, stall counter width
BUBBLE_KEEP_PC, 1, 1: a bubble carries pc_in; 0: a bubble carries PC 0

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
stall  in  1  hold current contents (downstream not ready / hazard)
flush  in  1  kill contents (exception/eret redirect)
bubble  in  1  insert NOP (upstream stalled, this stage must advance)
flush_pc  in  PC_W  PC value written on flush
ir_in  in  IR_W  instruction from previous stage
pc_in  in  PC_W  PC from previous stage
exc_in  in  EXC_W  exception code from previous stage
bd_in  in  1  instruction sits in a branch delay slot
valid_in  in  1  previous stage holds a real instruction
ir_out  out  IR_W  registered instruction
pc_out  out  PC_W  registered PC
exc_out  out  EXC_W  registered exception code
bd_out  out  1  registered delay-slot flag
valid_out  out  1  registered valid
stall_cnt  out  CNT_W  cycles spent stalled since reset

Behaviour:
- Single clock domain. All state updates on the rising edge of clk. Synchronous, active-high reset. Latency is 1 cycle for every field. No combinational path from input to output.
- Control priority, evaluated per edge: reset > flush > stall > bubble > load.
- reset: ir_out=0, pc_out=RESET_PC, exc_out=0, bd_out=0, valid_out=0, stall_cnt=0.
- flush: ir_out=0, pc_out=flush_pc, exc_out=0, bd_out=0, valid_out=0. stall_cnt is unchanged. Flush overrides a simultaneous stall, so a stalled stage is still killed.
- stall, with no reset or flush: every field holds. stall_cnt increments by 1 and saturates at 2^CNT_W-1; it never wraps.
- bubble, with no reset, flush or stall: ir_out=0, exc_out=0, bd_out=0, valid_out=0. pc_out=pc_in when BUBBLE_KEEP_PC=1, else pc_out=0. stall_cnt is unchanged.
- load (none of the above asserted): ir_out=ir_in, pc_out=pc_in, bd_out=bd_in, valid_out=valid_in. exc_out=exc_in if valid_in=1, else exc_out=0 (exceptions on invalid slots are dropped).
- Controls are treated as strictly 1/0. Any X/Z on stall, flush or bubble is treated as deasserted, except reset.
- Reset asserted mid-stall clears stall_cnt that cycle. The counter resumes from 0 on the next stalled cycle.
- No initial blocks. Reset is the only initialisation. Use nonblocking assignments only.
- Output values after reset must be valid for the first instruction fetch: valid_out=0 means downstream ignores ir_out.

Test Plan:
- Reset: hold reset 2 cycles with ir_in=32'h3c011234 -> all outputs 0 except pc_out=32'h00003000; stall_cnt=0.
- Load: ir_in=32'h24020005, pc_in=32'h00003004, valid_in=1, exc_in=0, bd_in=1 -> next cycle outputs match exactly, bd_out=1. Repeat with valid_in=0, exc_in=5'd4 -> exc_out=0.
- Stall: load ir=32'h8c030000, then stall 3 cycles while ir_in changes -> ir_out stays 32'h8c030000 and stall_cnt=3. Deassert -> new value loads the next cycle.
- Flush over stall: stall=1, flush=1, flush_pc=32'h00004180 -> valid_out=0, ir_out=0, pc_out=32'h00004180, stall_cnt unchanged.
- Bubble: bubble=1, pc_in=32'h00003010 -> ir_out=0, valid_out=0, pc_out=32'h00003010. Rerun with BUBBLE_KEEP_PC=0 -> pc_out=0.
- Saturation: CNT_W=3, stall 10 cycles -> stall_cnt reads 7 from the 7th cycle on. Assert reset during the stall -> stall_cnt=0 the next cycle.
